// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: state encoding, frame
// defaults and the bit-counter width helper.
package spi_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_e;

  localparam int         SPI_DATA_W     = 8;
  localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus tx/rx byte handshakes of the SPI responder.
import spi_pkg::*;

interface spi_slave_if #(
  parameter int DATA_W = SPI_DATA_W
);

  logic              i_ss;
  logic              i_mosi;
  logic              o_miso;
  logic              i_tx_valid;
  logic [DATA_W-1:0] i_tx_byte;
  logic              o_tx_ready;
  logic              o_rx_valid;
  logic [DATA_W-1:0] o_rx_byte;
  logic              o_busy;
  logic              o_frame_err;

  modport slave (
    input  i_ss, i_mosi,
    input  i_tx_valid, i_tx_byte,
    output o_miso, o_tx_ready,
    output o_rx_valid, o_rx_byte,
    output o_busy, o_frame_err
  );

  modport master (
    output i_ss, i_mosi,
    output i_tx_valid, i_tx_byte,
    input  o_miso, o_tx_ready,
    input  o_rx_valid, o_rx_byte,
    input  o_busy, o_frame_err
  );

endinterface

// File: rtl/spi_tx_hold_buf.sv
// Single-entry transmit holding buffer: valid/ready write side,
// consume strobe on the read side.
import spi_pkg::*;

module spi_tx_hold_buf #(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              consume,
  output logic              buf_full,
  output logic [DATA_W-1:0] buf_data
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // consume only fires while full and writes only land while
  // empty, so a same-edge write always sees the old empty state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (consume)
        full_q <= 1'b0;
      if (wr_valid && !full_q) begin
        full_q <= 1'b1;
        data_q <= wr_data;
      end
    end
  end

  assign wr_ready = !full_q;
  assign buf_full = full_q;
  assign buf_data = data_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, MSB-first, clocked by the SPI bit clock.
// Define SPI_SLAVE_ECHO_EN to echo the last rx byte when no tx byte is held.
import spi_pkg::*;

module spi_slave #(
  parameter int                DATA_W     = SPI_DATA_W,
  parameter logic [DATA_W-1:0] DEFAULT_TX = DATA_W'(SPI_DEFAULT_TX)
) (
  input  logic         i_sclk,
  input  logic         i_reset,
  spi_slave_if.slave   bus
);

  localparam int CNT_W = cnt_w(DATA_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rxb_q, rxb_d;
  logic              rxv_q, rxv_d;
  logic              ferr_q, ferr_d;

  logic              consume;
  logic              buf_full;
  logic              wr_ready;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] rx_new;
  logic [DATA_W-1:0] fill_idle;
  logic [DATA_W-1:0] fill_last;
  logic [DATA_W-1:0] next_idle;
  logic              last_bit;

  spi_tx_hold_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk      (i_sclk),
    .rst_n    (i_reset),
    .wr_valid (bus.i_tx_valid),
    .wr_ready (wr_ready),
    .wr_data  (bus.i_tx_byte),
    .consume  (consume),
    .buf_full (buf_full),
    .buf_data (buf_data)
  );

  assign rx_new   = {rx_q[DATA_W-2:0], bus.i_mosi};
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef SPI_SLAVE_ECHO_EN
  assign fill_idle = rxb_q;
  assign fill_last = rx_new;
`else
  assign fill_idle = DEFAULT_TX;
  assign fill_last = DEFAULT_TX;
`endif

  assign next_idle = buf_full ? buf_data : fill_idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rxb_d   = rxb_q;
    rxv_d   = 1'b0;
    ferr_d  = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_ss) begin
          tx_d  = next_idle;
          cnt_d = '0;
        end else begin
          // this edge already samples bit 0 of the frame
          state_d = SHIFT;
          rx_d    = rx_new;
          tx_d    = tx_q << 1;
          cnt_d   = CNT_W'(1);
          consume = buf_full;
        end
      end
      SHIFT: begin
        if (bus.i_ss) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
          tx_d    = next_idle;
        end else if (last_bit) begin
          rx_d    = rx_new;
          rxb_d   = rx_new;
          rxv_d   = 1'b1;
          cnt_d   = '0;
          tx_d    = buf_full ? buf_data : fill_last;
          consume = buf_full;
        end else begin
          rx_d  = rx_new;
          tx_d  = tx_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= DEFAULT_TX;
      rxb_q   <= '0;
      rxv_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rxb_q   <= rxb_d;
      rxv_q   <= rxv_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.o_miso      = tx_q[DATA_W-1];
  assign bus.o_tx_ready  = wr_ready;
  assign bus.o_rx_valid  = rxv_q;
  assign bus.o_rx_byte   = rxb_q;
  assign bus.o_busy      = (state_q == SHIFT);
  assign bus.o_frame_err = ferr_q;

endmodule
